// File: rtl/y86_pkg.sv
// Shared Y86 encodings and helpers for the execute stage: instruction codes,
// ALU/condition function codes, status codes and the condition evaluator.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_ANDN = 4'h5;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // cc is packed {ZF, SF, OF}
  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifun)
      C_ALWAYS: cond_eval = 1'b1;
      C_LE:     cond_eval = (sf ^ of) | zf;
      C_L:      cond_eval = sf ^ of;
      C_E:      cond_eval = zf;
      C_NE:     cond_eval = !zf;
      C_GE:     cond_eval = !(sf ^ of);
      C_G:      cond_eval = !(sf ^ of) && !zf;
      default:  cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic alu_op_valid(input logic [3:0] ifun, input logic ext);
    alu_op_valid = (ifun <= ALU_XOR) || (ext && (ifun == ALU_OR || ifun == ALU_ANDN));
  endfunction

endpackage

// File: rtl/y86_execute_pipe_if.sv
// Handshake and data bundle between the E-register side and the memory stage.
interface y86_execute_pipe_if #(parameter int unsigned WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_icode;
  logic [3:0]       in_ifun;
  logic [2:0]       in_stat;
  logic [WIDTH-1:0] in_valA;
  logic [WIDTH-1:0] in_valB;
  logic [WIDTH-1:0] in_valC;
  logic [3:0]       in_dstE;
  logic [3:0]       in_dstM;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_icode;
  logic [2:0]       out_stat;
  logic             out_cnd;
  logic [WIDTH-1:0] out_valE;
  logic [WIDTH-1:0] out_valA;
  logic [3:0]       out_dstE;
  logic [3:0]       out_dstM;
  logic [2:0]       cc;

  modport master (
    output in_valid, in_icode, in_ifun, in_stat, in_valA, in_valB, in_valC,
           in_dstE, in_dstM, flush, out_ready,
    input  in_ready, out_valid, out_icode, out_stat, out_cnd, out_valE, out_valA,
           out_dstE, out_dstM, cc
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_stat, in_valA, in_valB, in_valC,
           in_dstE, in_dstM, flush, out_ready,
    output in_ready, out_valid, out_icode, out_stat, out_cnd, out_valE, out_valA,
           out_dstE, out_dstM, cc
  );
endinterface

// File: rtl/y86_alu.sv
// Combinational Y86 ALU computing b OP a with ZF/SF/OF; unsupported ops give 0.
module y86_alu
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter bit          EXT_ALU = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ifun,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);
  localparam int unsigned MSB = WIDTH - 1;

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (ifun)
      ALU_ADD: begin
        result = b + a;
        of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
      end
      ALU_AND:  result = b & a;
      ALU_XOR:  result = b ^ a;
      ALU_OR:   if (EXT_ALU) result = b | a;
      ALU_ANDN: if (EXT_ALU) result = b & ~a;
      default:  ;
    endcase
    zf = (result == '0);
    sf = result[MSB];
  end
endmodule

// File: rtl/y86_execute_pipe.sv
// Pipelined Y86 execute stage: valE, branch/cmov condition, CC register and
// a single output register with a combinational valid/ready handshake.
module y86_execute_pipe
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter bit          EXT_ALU = 1'b0
) (
  input logic               clk,
  input logic               rst,
  y86_execute_pipe_if.slave bus
);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

  logic             r_out_valid;
  logic [3:0]       r_icode;
  logic [2:0]       r_stat;
  logic             r_cnd;
  logic [WIDTH-1:0] r_valE;
  logic [WIDTH-1:0] r_valA;
  logic [3:0]       r_dstE;
  logic [3:0]       r_dstM;
  logic [2:0]       r_cc;
  logic             r_halted;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_zf, w_sf, w_of;
  logic [WIDTH-1:0] w_valE;
  logic             w_cnd;
  logic [3:0]       w_dstE;
  logic             w_cc_we;

  y86_alu #(.WIDTH(WIDTH), .EXT_ALU(EXT_ALU)) u_alu (
    .a      (bus.in_valA),
    .b      (bus.in_valB),
    .ifun   (bus.in_ifun),
    .result (w_alu_result),
    .zf     (w_zf),
    .sf     (w_sf),
    .of     (w_of)
  );

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

  always_comb begin
    w_valE = '0;
    case (bus.in_icode)
      IOPQ:             w_valE = w_alu_result;
      IRRMOVQ:          w_valE = bus.in_valA;
      IIRMOVQ:          w_valE = bus.in_valC;
      IRMMOVQ, IMRMOVQ: w_valE = bus.in_valB + bus.in_valC;
      ICALL, IPUSHQ:    w_valE = bus.in_valB - STEP;
      IRET, IPOPQ:      w_valE = bus.in_valB + STEP;
      default:          w_valE = '0;
    endcase
  end

  // Condition sees the CC as it stands before this instruction's own update.
  assign w_cnd   = ((bus.in_icode == IRRMOVQ) || (bus.in_icode == IJXX)) &&
                   cond_eval(r_cc, bus.in_ifun);
  assign w_dstE  = ((bus.in_icode == IRRMOVQ) && !w_cnd) ? RNONE : bus.in_dstE;
  assign w_cc_we = w_accept && (bus.in_icode == IOPQ) && (bus.in_stat == SAOK) &&
                   !r_halted && alu_op_valid(bus.in_ifun, EXT_ALU);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_icode     <= '0;
      r_stat      <= '0;
      r_cnd       <= 1'b0;
      r_valE      <= '0;
      r_valA      <= '0;
      r_dstE      <= RNONE;
      r_dstM      <= RNONE;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_icode     <= bus.in_icode;
      r_stat      <= bus.in_stat;
      r_cnd       <= w_cnd;
      r_valE      <= w_valE;
      r_valA      <= bus.in_valA;
      r_dstE      <= w_dstE;
      r_dstM      <= bus.in_dstM;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc     <= 3'b100;
      r_halted <= 1'b0;
    end else begin
      if (w_cc_we) r_cc <= {w_zf, w_sf, w_of};
      if (w_accept && (bus.in_stat != SAOK)) r_halted <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_icode = r_icode;
  assign bus.out_stat  = r_stat;
  assign bus.out_cnd   = r_cnd;
  assign bus.out_valE  = r_valE;
  assign bus.out_valA  = r_valA;
  assign bus.out_dstE  = r_dstE;
  assign bus.out_dstM  = r_dstM;
  assign bus.cc        = r_cc;
endmodule

// File: tb/tb_y86_execute_pipe.sv
// Bench for y86_execute_pipe: 64-bit base and 32-bit extended-ALU instances
// driven in lockstep and compared every cycle against a behavioural model.
module tb_y86_execute_pipe;

  typedef struct packed {
    logic        ov;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [2:0]  cc;
    logic        halted;
  } ms_t;

  typedef struct packed {
    logic        v;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [2:0]  stat;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [3:0]  dE;
    logic [3:0]  dM;
  } in_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  in_t  cur;
  logic ordy;
  logic fl;
  ms_t  m64, m32, n64, n32;
  logic [2:0] saved64, saved32;

  y86_execute_pipe_if #(.WIDTH(64)) bus64 ();
  y86_execute_pipe_if #(.WIDTH(32)) bus32 ();

  y86_execute_pipe #(.WIDTH(64), .EXT_ALU(1'b0)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
  y86_execute_pipe #(.WIDTH(32), .EXT_ALU(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference ----------------
  function automatic logic [63:0] msk(input int unsigned w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Two's-complement value of a w-bit pattern as a wide signed integer
  function automatic logic signed [65:0] sx(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    m = msk(w);
    if (v[w-1]) return $signed({2'b11, v | ~m});
    else        return $signed({2'b00, v & m});
  endfunction

  function automatic logic mcond(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of, less;
    {zf, sf, of} = cc;
    less = (sf != of);
    case (ifun)
      4'd0:    return 1'b1;
      4'd1:    return less || zf;
      4'd2:    return less;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !less;
      4'd6:    return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ms_t mreset();
    ms_t s;
    s = '0;
    s.dstE = 4'hF;
    s.dstM = 4'hF;
    s.cc   = 3'b100;
    return s;
  endfunction

  function automatic ms_t model(input ms_t s, input int unsigned w, input bit ext,
                                input in_t x, input logic rdy, input logic flush);
    ms_t n;
    logic [63:0] m, a, b, c, r;
    logic signed [65:0] t, smax, smin;
    bit opok, acc, cnd, of;
    n = s;
    m = msk(w);
    a = x.a & m; b = x.b & m; c = x.c & m;
    smax = sx(m >> 1, w);
    smin = sx(m & ~(m >> 1), w);
    acc  = x.v && (!s.ov || rdy) && !flush;
    r = '0; opok = 0; of = 0;
    case (x.icode)
      4'h6: case (x.ifun)
        4'd0: begin r = b + a; t = sx(b, w) + sx(a, w); of = (t > smax) || (t < smin); opok = 1; end
        4'd1: begin r = b - a; t = sx(b, w) - sx(a, w); of = (t > smax) || (t < smin); opok = 1; end
        4'd2: begin r = b & a; opok = 1; end
        4'd3: begin r = b ^ a; opok = 1; end
        4'd4: if (ext) begin r = b | a; opok = 1; end
        4'd5: if (ext) begin r = b & ~a; opok = 1; end
        default: ;
      endcase
      4'h2:       r = a;
      4'h3:       r = c;
      4'h4, 4'h5: r = b + c;
      4'h8, 4'hA: r = b - 64'(w / 8);
      4'h9, 4'hB: r = b + 64'(w / 8);
      default:    r = '0;
    endcase
    r &= m;
    cnd = (x.icode == 4'h2 || x.icode == 4'h7) ? mcond(s.cc, x.ifun) : 1'b0;
    if (flush) n.ov = 1'b0;
    else if (acc) begin
      n.ov    = 1'b1;
      n.icode = x.icode;
      n.stat  = x.stat;
      n.cnd   = cnd;
      n.valE  = r;
      n.valA  = a;
      n.dstE  = (x.icode == 4'h2 && !cnd) ? 4'hF : x.dE;
      n.dstM  = x.dM;
    end else if (rdy) n.ov = 1'b0;
    if (acc && x.icode == 4'h6 && x.stat == 3'd1 && !s.halted && opok)
      n.cc = {(r == 64'd0), r[w-1], of};
    if (acc && x.stat != 3'd1) n.halted = 1'b1;
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ms_t snap64();
    ms_t d;
    d = '0;
    d.ov = bus64.out_valid; d.icode = bus64.out_icode; d.stat = bus64.out_stat;
    d.cnd = bus64.out_cnd; d.valE = bus64.out_valE; d.valA = bus64.out_valA;
    d.dstE = bus64.out_dstE; d.dstM = bus64.out_dstM; d.cc = bus64.cc;
    return d;
  endfunction

  function automatic ms_t snap32();
    ms_t d;
    d = '0;
    d.ov = bus32.out_valid; d.icode = bus32.out_icode; d.stat = bus32.out_stat;
    d.cnd = bus32.out_cnd; d.valE = 64'(bus32.out_valE); d.valA = 64'(bus32.out_valA);
    d.dstE = bus32.out_dstE; d.dstM = bus32.out_dstM; d.cc = bus32.cc;
    return d;
  endfunction

  task automatic check_state(input string p, input ms_t d, input ms_t e,
                             input logic rd, input logic re);
    chk({p, "_in_ready"}, 64'(rd), 64'(re));
    chk({p, "_out_valid"}, 64'(d.ov), 64'(e.ov));
    chk({p, "_out_icode"}, 64'(d.icode), 64'(e.icode));
    chk({p, "_out_stat"}, 64'(d.stat), 64'(e.stat));
    chk({p, "_out_cnd"}, 64'(d.cnd), 64'(e.cnd));
    chk({p, "_out_valE"}, d.valE, e.valE);
    chk({p, "_out_valA"}, d.valA, e.valA);
    chk({p, "_out_dstE"}, 64'(d.dstE), 64'(e.dstE));
    chk({p, "_out_dstM"}, 64'(d.dstM), 64'(e.dstM));
    chk({p, "_cc"}, 64'(d.cc), 64'(e.cc));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive();
    bus64.in_valid = cur.v;      bus32.in_valid = cur.v;
    bus64.in_icode = cur.icode;  bus32.in_icode = cur.icode;
    bus64.in_ifun  = cur.ifun;   bus32.in_ifun  = cur.ifun;
    bus64.in_stat  = cur.stat;   bus32.in_stat  = cur.stat;
    bus64.in_valA  = cur.a;      bus32.in_valA  = cur.a[31:0];
    bus64.in_valB  = cur.b;      bus32.in_valB  = cur.b[31:0];
    bus64.in_valC  = cur.c;      bus32.in_valC  = cur.c[31:0];
    bus64.in_dstE  = cur.dE;     bus32.in_dstE  = cur.dE;
    bus64.in_dstM  = cur.dM;     bus32.in_dstM  = cur.dM;
    bus64.out_ready = ordy;      bus32.out_ready = ordy;
    bus64.flush    = fl;         bus32.flush    = fl;
  endtask

  // Called at posedge+1: drive, check at negedge, advance model at posedge
  task automatic step();
    drive();
    @(negedge clk);
    check_state("w64", snap64(), m64, bus64.in_ready, !m64.ov || ordy);
    check_state("w32", snap32(), m32, bus32.in_ready, !m32.ov || ordy);
    n64 = model(m64, 64, 1'b0, cur, ordy, fl);
    n32 = model(m32, 32, 1'b1, cur, ordy, fl);
    @(posedge clk);
    #1;
    m64 = n64;
    m32 = n32;
  endtask

  task automatic setop(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] dE,
                       input logic [3:0] dM);
    cur.v = 1'b1; cur.icode = icode; cur.ifun = ifun; cur.stat = 3'd1;
    cur.a = a; cur.b = b; cur.c = c; cur.dE = dE; cur.dM = dM;
  endtask

  task automatic idle();
    cur = '0;
    cur.stat = 3'd1;
    cur.dE = 4'hF;
    cur.dM = 4'hF;
  endtask

  function automatic logic [63:0] rv();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    clk = 1'b0; rst = 1'b1; n_assert = 0; n_fail = 0;
    ordy = 1'b1; fl = 1'b0;
    idle();
    drive();
    m64 = mreset(); m32 = mreset();
    #2;
    check_state("rst64", snap64(), m64, bus64.in_ready, 1'b1);
    check_state("rst32", snap32(), m32, bus32.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // sub then branch
    setop(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2, 4'hF); step();
    chk("sub_valE", bus64.out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_cc", 64'(bus64.cc), 64'(3'b010));
    setop(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF); step();
    chk("jl_cnd", 64'(bus64.out_cnd), 64'd1);
    setop(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF); step();
    chk("je_cnd", 64'(bus64.out_cnd), 64'd0);

    // overflow then cmovle
    setop(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF); step();
    chk("ovf_valE", bus64.out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("ovf_cc", 64'(bus64.cc), 64'(3'b011));
    setop(4'h2, 4'h1, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF); step();
    chk("cmov_cnd", 64'(bus64.out_cnd), 64'd0);
    chk("cmov_dstE", 64'(bus64.out_dstE), 64'hF);

    // backpressure
    idle(); step();
    ordy = 1'b0;
    setop(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h5, 4'hF); step();
    chk("bp_valE", bus64.out_valE, 64'd3);
    chk("bp_cc", 64'(bus64.cc), 64'(3'b000));
    setop(4'h6, 4'h3, 64'd5, 64'd5, 64'd0, 4'h6, 4'hF);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", 64'(bus64.in_ready), 64'd0);
      chk("stall_valE", bus64.out_valE, 64'd3);
      chk("stall_cc", 64'(bus64.cc), 64'(3'b000));
    end
    ordy = 1'b1; step();
    chk("release_valE", bus64.out_valE, 64'd0);
    chk("release_dstE", 64'(bus64.out_dstE), 64'h6);
    chk("release_cc", 64'(bus64.cc), 64'(3'b100));

    // stack arithmetic
    setop(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'hF); step();
    chk("push64", bus64.out_valE, 64'hF8);
    chk("push32", 64'(bus32.out_valE), 64'hFC);
    setop(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'h5); step();
    chk("pop64", bus64.out_valE, 64'h108);
    chk("pop32", 64'(bus32.out_valE), 64'h104);

    // extended ALU ops exist only on the 32-bit instance
    setop(4'h6, 4'h4, 64'h0F0, 64'h00F, 64'd0, 4'h1, 4'hF); step();
    chk("or32", 64'(bus32.out_valE), 64'hFF);
    chk("or64_disabled", bus64.out_valE, 64'd0);
    chk("or64_cc_hold", 64'(bus64.cc), 64'(3'b100));

    // flush drops held output and the presented instruction
    setop(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h1, 4'hF); step();
    ordy = 1'b0; fl = 1'b1;
    setop(4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h1, 4'hF); step();
    chk("flush_out_valid", 64'(bus64.out_valid), 64'd0);
    chk("flush_cc", 64'(bus64.cc), 64'(3'b000));
    fl = 1'b0; ordy = 1'b1;

    // randomized phase
    for (int unsigned i = 0; i < 600; i++) begin
      cur.v     = ($urandom_range(0, 9) != 0);
      cur.icode = 4'($urandom_range(0, 15));
      cur.ifun  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      cur.stat  = 3'd1;
      cur.a = rv(); cur.b = rv(); cur.c = rv();
      cur.dE = 4'($urandom_range(0, 15));
      cur.dM = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 9) == 0);
      step();
    end

    // halt freeze
    idle(); ordy = 1'b1; fl = 1'b0; step();
    saved64 = m64.cc; saved32 = m32.cc;
    setop(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF);
    cur.stat = 3'd4;
    step();
    chk("halt_stat", 64'(bus64.out_stat), 64'd4);
    chk("halt_cc64", 64'(bus64.cc), 64'(saved64));
    setop(4'h6, 4'h3, 64'd0, 64'd0, 64'd0, 4'h2, 4'hF); step();
    chk("halted_cc64", 64'(bus64.cc), 64'(saved64));
    chk("halted_cc32", 64'(bus32.cc), 64'(saved32));

    // reset in the middle of a stall
    ordy = 1'b0;
    setop(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 4'h2, 4'hF); step();
    chk("pre_rst_stall", 64'(bus64.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus64.out_valid), 64'd0);
    chk("mid_rst_cc", 64'(bus64.cc), 64'(3'b100));
    chk("mid_rst_dstE", 64'(bus64.out_dstE), 64'hF);
    m64 = mreset(); m32 = mreset();
    @(posedge clk); #1;
    rst = 1'b0;
    ordy = 1'b1; idle(); step();
    setop(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2, 4'hF); step();
    chk("post_rst_cc", 64'(bus64.cc), 64'(3'b010));
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_execute_pipe.md
# y86_execute_pipe

Parametrised, pipelined execute stage for the Y86 processor, the successor to the single-cycle SEQ execute block. It sits between the decode/E-register boundary and the memory stage. It computes valE, evaluates the jump/cmov condition and maintains the condition-code register. A valid/ready handshake supports stalls, and a flush input supports mispredict squash and exception freeze.

## Interface
- WIDTH, 64: datapath width in bits. Must be a multiple of 8 and at least 16.
- EXT_ALU, 0: when 1, enables ifun 4 (OR) and ifun 5 (AND-NOT, valB & ~valA) for OPq.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_icode, in_ifun  in  4 each  decoded instruction fields.
- in_stat  in  3  status: AOK=1, HLT=2, ADR=3, INS=4.
- in_valA, in_valB, in_valC  in  WIDTH each  operands.
- in_dstE, in_dstM  in  4 each  destination registers; 0xF = RNONE.
- flush  in  1  squash the held output and any instruction accepted this cycle.
- out_valid  out  1  result register holds a live instruction.
- out_ready  in  1  downstream consumes the result.
- out_icode  out  4  instruction field carried to the memory stage.
- out_stat  out  3  status carried to the memory stage.
- out_cnd  out  1  condition result.
- out_valE, out_valA  out  WIDTH each  result and pass-through operand.
- out_dstE, out_dstM  out  4 each  destination registers.
- cc  out  3  {ZF, SF, OF}.

## Operation
- Accept condition: in_valid && in_ready && !flush.
- in_ready = !out_valid || out_ready. This is combinational, with no skid buffer.
- valE by icode:
  - OPq(6): valB op valA.
  - rrmovq/cmovXX(2): valA.
  - irmovq(3): valC.
  - rmmovq(4), mrmovq(5): valB + valC.
  - call(8), pushq(A): valB − WIDTH/8.
  - ret(9), popq(B): valB + WIDTH/8.
  - All other icodes: 0.
- ALU ops for OPq:
  - ifun 0 add, 1 sub (valB − valA), 2 and, 3 xor.
  - ifun 4/5 only when EXT_ALU=1.
  - Any other ifun yields valE = 0 and no CC update.
- All arithmetic is modulo 2^WIDTH.
- Condition codes for OPq:
  - ZF = (valE == 0); SF = valE[WIDTH-1].
  - OF for add: operand signs equal and result sign differs.
  - OF for sub: valB sign differs from valA sign and result sign differs from valB.
  - OF = 0 for logical ops.
- CC write rule: CC updates only on accept of an OPq with in_stat == AOK and the halted flag clear.
- Condition evaluation uses the current CC (before the accepting instruction's own update):
  - ifun 0 always, 1 le ((SF^OF)|ZF), 2 l (SF^OF), 3 e (ZF), 4 ne (!ZF), 5 ge (!(SF^OF)), 6 g (!(SF^OF)&!ZF).
  - ifun 7–15 yields cnd = 0.
  - out_cnd is set for icode 2 and 7; it is 0 otherwise.
- cmovXX with cnd = 0 forces out_dstE = 0xF.
- Halted flag:
  - Set on accept of any instruction with in_stat != AOK.
  - Cleared only by rst.
  - Later instructions still pass through but never update CC.
- Flush:
  - Clears out_valid on the next edge.
  - An instruction presented in the flush cycle is not accepted and has no CC effect.
  - CC and the halted flag are otherwise untouched.

## Timing
- Latency is one cycle from accept to out_valid.
- CC and halted update on the same edge that captures the instruction.
- Stall (out_valid && !out_ready):
  - All out_* fields hold.
  - in_ready = 0.
  - CC holds.
- Simultaneous out_ready and accept: the output register is replaced in the same edge, giving back-to-back throughput of 1 per cycle.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid = 0; all out_* data = 0; out_dstE/out_dstM = 0xF.
  - cc = {1,0,0}; halted = 0.
- Reset release takes effect on the first rising edge.

## Structure
- Shared package y86_pkg holds:
  - icode constants (IHALT..IPOPQ), ALU ifun constants, condition ifun constants.
  - stat codes, RNONE.
  - cond_eval function (cc, ifun) returning cnd.
- Sub-module y86_alu, combinational, parametrised by WIDTH/EXT_ALU: inputs a, b, ifun; outputs result, zf, sf, of.
- Top level holds the result register, the CC register, the halted flag and the handshake.

## Test plan
- Sub then branch: OPq sub with valA=5, valB=3 → valE=0xFFFF_FFFF_FFFF_FFFE and cc={0,1,0}. Next jXX ifun 2 (l) → out_cnd=1; jXX ifun 3 (e) → out_cnd=0.
- Overflow then cmov: add with valA=valB=0x7FFF_FFFF_FFFF_FFFF → valE=0xFFFF_FFFF_FFFF_FFFE, cc={0,1,1}. Next cmov ifun 1 (le) with dstE=3 → out_cnd=0, out_dstE=0xF.
- Backpressure: out_ready=0 for 3 cycles after accepting an add → outputs hold, in_ready=0, cc changes exactly once. Release → next instruction accepted the same cycle.
- Stack arithmetic: pushq with valB=0x100 → 0xF8; popq → 0x108. Repeat with WIDTH=32 → pushq gives 0xFC.
- Halt freeze: OPq with stat INS → cc unchanged, out_stat=4. A following AOK xor 0,0 → cc still unchanged. Assert rst mid-stall → out_valid=0, cc={1,0,0} immediately.
- Flush: flush asserted with in_valid=1 on an OPq → no output next cycle, cc unchanged, held output dropped.
